camera_capture: RTL and testbench
=================================

CAMERA_CAPTURE -- requirements
Module: camera_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640: maximum pixels per line that are forwarded.
REQ-002 Parameter V_ACTIVE, default 480: maximum lines per frame that are forwarded.
REQ-003 clk  input  1  system clock; the block uses this single clock only.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 camPclk  input  1  camera pixel clock, sampled as data in the clk domain.
REQ-006 camVsync  input  1  camera frame sync; high during vertical blank.
REQ-007 camHref  input  1  camera line-valid; high while line bytes are presented.
REQ-008 camData  input  8  camera byte bus; RGB565, high byte first.
REQ-009 outX  output  10  column of the current pixel, 0..H_ACTIVE-1.
REQ-010 outY  output  9  row of the current pixel, 0..V_ACTIVE-1.
REQ-011 outPixel  output  16  assembled RGB565 pixel {hi byte, lo byte}.
REQ-012 pixelValid  output  1  one-clk pulse; outX, outY and outPixel are valid on this pulse.
REQ-013 frameDone  output  1  one-clk pulse at the end of each captured frame.

Function
REQ-014 camPclk, camVsync, camHref and camData SHALL pass through a 2-flop synchronizer and are then treated as aligned samples.
REQ-015 A pclk rise SHALL be detected as synced pclk = 1 while the previous synced sample = 0. Only then are href and data sampled.
REQ-016 clk SHALL be at least 4x camPclk. Behaviour below that ratio is undefined.
REQ-017 FSM states: S_WAIT, S_VBLANK, S_ACTIVE.
REQ-018 S_WAIT -> S_VBLANK when synced vsync = 1; this aligns capture to a frame start.
REQ-019 S_VBLANK -> S_ACTIVE on synced vsync falling; col, row and the byte phase are cleared on this transition.
REQ-020 S_ACTIVE -> S_VBLANK on synced vsync rising; frameDone pulses in the next cycle.
REQ-021 In S_ACTIVE, on a pclk rise with href = 1:
  - phase 0: latch the high byte.
  - phase 1: form outPixel, load outX = col and outY = row, then increment col.
  - The phase toggles on each such rise.
REQ-022 pixelValid SHALL pulse exactly 1 clk after the phase-1 pclk-rise cycle, and only if col < H_ACTIVE and row < V_ACTIVE.
REQ-023 Pixels beyond H_ACTIVE or V_ACTIVE SHALL be dropped silently; col saturates at H_ACTIVE.
REQ-024 On synced href falling in S_ACTIVE:
  - phase clears to 0 and col clears to 0;
  - row increments, saturating at V_ACTIVE, only if col > 0.
  - An odd trailing byte is discarded.
REQ-025 Between pulses, outX, outY and outPixel SHALL hold their last values; pixelValid and frameDone are 0 except during their pulses.
REQ-026 Simultaneous vsync rise and href fall in one cycle: the vsync transition takes priority and frameDone pulses once.
REQ-027 A pclk rise with href = 0 SHALL have no effect; no pixel is produced in S_WAIT or S_VBLANK.
REQ-028 Width rules:
  - col is 10 bits and row is 9 bits, with no wrap (saturating).
  - outPixel = {hi[7:0], lo[7:0]}, unmodified.

Reset
REQ-029 While reset = 1, state = S_WAIT, and synchronizers, col, row, phase and all outputs SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL abort capture; after release, no pixelValid occurs until a full vsync high -> low sequence is seen.

Structure
REQ-031 H_ACTIVE/V_ACTIVE defaults and the RGB565 field positions (R[15:11], G[10:5], B[4:0]) SHALL live in the shared video package with the frame-buffer bias constants.
REQ-032 The FSM state encoding SHALL be local to this module.
REQ-033 Sub-module sync2 (2-flop synchronizer, width-parameterized) SHALL be instantiated for the control and data inputs.

Verification
REQ-034 Reset with clk 100 MHz, pclk 25 MHz; vsync pulse, then one href line of bytes 0xF8,0x00,0x07,0xE0 -> two pulses: (0,0,0xF800) and (1,0,0x07E0); no frameDone.
REQ-035 Full 640x480 frame then vsync rise -> exactly 307200 pixelValid pulses, last at (639,479), then one frameDone.
REQ-036 Line of 1300 bytes (650 pixels) -> 640 pulses for that row; row advances by 1 at href fall.
REQ-037 Line with an odd byte count of 5 -> 2 pulses; the next line starts at outX = 0 with the correct hi/lo pairing.
REQ-038 Reset asserted for 3 clks mid-line at pixel 100 -> outputs 0; pixels of the rest of that frame are ignored; the next frame starts at (0,0).
REQ-039 Camera powered with vsync already low, href toggling -> no pixelValid until the first vsync high -> low sequence.

Source files
------------

// File: rtl/camera_capture_pkg.sv
// Shared video definitions: active-window defaults, RGB565 field layout,
// frame-buffer bias constants and byte-pair packing.
package camera_capture_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam int CAM_DATA_W = 8;
    localparam int COL_W      = 10;
    localparam int ROW_W      = 9;
    localparam int PIX_W      = 16;

    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    localparam logic [31:0] FB_BASE_BIAS   = 32'h0000_0000;
    localparam int          FB_LINE_STRIDE = H_ACTIVE_DEF;

    // Camera sends the high byte first; the pixel is the bytes side by side.
    function automatic logic [PIX_W-1:0] packRgb565(input logic [CAM_DATA_W-1:0] hi,
                                                     input logic [CAM_DATA_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/camera_capture_if.sv
// Camera byte bus in, assembled pixel stream out.
interface camera_capture_if;
    import camera_capture_pkg::*;

    logic                  camPclk;
    logic                  camVsync;
    logic                  camHref;
    logic [CAM_DATA_W-1:0] camData;
    logic [COL_W-1:0]      outX;
    logic [ROW_W-1:0]      outY;
    logic [PIX_W-1:0]      outPixel;
    logic                  pixelValid;
    logic                  frameDone;

    modport master (
        output camPclk, camVsync, camHref, camData,
        input  outX, outY, outPixel, pixelValid, frameDone
    );

    modport slave (
        input  camPclk, camVsync, camHref, camData,
        output outX, outY, outPixel, pixelValid, frameDone
    );

endinterface

// File: rtl/camera_capture_sync2.sv
// Width-parameterized two-flop synchronizer with asynchronous clear.
module camera_capture_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/camera_capture.sv
// Oversampled DVP camera capture: pairs RGB565 bytes into pixels with
// column/row coordinates, clipped to the active window.
module camera_capture
    import camera_capture_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    camera_capture_if.slave  cam
);

    typedef enum logic [1:0] {S_WAIT, S_VBLANK, S_ACTIVE} state_t;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_ACTIVE);

    function automatic logic [COL_W-1:0] colSatInc(input logic [COL_W-1:0] c);
        return (c < COL_MAX) ? c + COL_W'(1) : COL_MAX;
    endfunction

    function automatic logic [ROW_W-1:0] rowSatInc(input logic [ROW_W-1:0] r);
        return (r < ROW_MAX) ? r + ROW_W'(1) : ROW_MAX;
    endfunction

    state_t                state, nextState;
    logic [2:0]            ctl_p0;
    logic [CAM_DATA_W-1:0] data_p0;
    logic                  pclk_p0, vsync_p0, href_p0;
    logic                  pclk_p1, vsync_p1, href_p1;
    logic                  pclkRise, vsyncRise, vsyncFall, hrefFall;
    logic                  loadHi, emitPix, lineEnd, frameStart, frameEnd, inRange;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic                  phase;
    logic [CAM_DATA_W-1:0] hiByte;
    logic [COL_W-1:0]      x_p1;
    logic [ROW_W-1:0]      y_p1;
    logic [PIX_W-1:0]      pix_p1;
    logic                  vld_p1, done_p1;

    // Stage p0: synchronized camera samples
    camera_capture_sync2 #(.WIDTH(3)) uSyncCtl (
        .clk(clk), .reset(reset),
        .d({cam.camPclk, cam.camVsync, cam.camHref}), .q(ctl_p0)
    );
    camera_capture_sync2 #(.WIDTH(CAM_DATA_W)) uSyncData (
        .clk(clk), .reset(reset), .d(cam.camData), .q(data_p0)
    );

    assign pclk_p0  = ctl_p0[2];
    assign vsync_p0 = ctl_p0[1];
    assign href_p0  = ctl_p0[0];

    assign pclkRise  = pclk_p0 & ~pclk_p1;
    assign vsyncRise = vsync_p0 & ~vsync_p1;
    assign vsyncFall = ~vsync_p0 & vsync_p1;
    assign hrefFall  = ~href_p0 & href_p1;
    assign inRange   = (col < COL_MAX) && (row < ROW_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_WAIT;
        else       state <= nextState;
    end

    // Vsync edges outrank line ends, which outrank byte strobes.
    always_comb begin
        nextState  = state;
        loadHi     = 1'b0;
        emitPix    = 1'b0;
        lineEnd    = 1'b0;
        frameStart = 1'b0;
        frameEnd   = 1'b0;
        case (state)
            S_WAIT: begin
                if (vsync_p0) nextState = S_VBLANK;
            end
            S_VBLANK: begin
                if (vsyncFall) begin
                    nextState  = S_ACTIVE;
                    frameStart = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (vsyncRise) begin
                    nextState = S_VBLANK;
                    frameEnd  = 1'b1;
                end else if (hrefFall) begin
                    lineEnd = 1'b1;
                end else if (pclkRise && href_p0) begin
                    loadHi  = ~phase;
                    emitPix = phase;
                end
            end
            default: nextState = S_WAIT;
        endcase
    end

    // Stage p1: counters, byte pairing and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pclk_p1  <= 1'b0;
            vsync_p1 <= 1'b0;
            href_p1  <= 1'b0;
            col      <= '0;
            row      <= '0;
            phase    <= 1'b0;
            hiByte   <= '0;
            x_p1     <= '0;
            y_p1     <= '0;
            pix_p1   <= '0;
            vld_p1   <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            pclk_p1  <= pclk_p0;
            vsync_p1 <= vsync_p0;
            href_p1  <= href_p0;
            vld_p1   <= emitPix && inRange;
            done_p1  <= frameEnd;
            if (frameStart) begin
                col   <= '0;
                row   <= '0;
                phase <= 1'b0;
            end
            if (lineEnd) begin
                col   <= '0;
                phase <= 1'b0;
                if (col != '0) row <= rowSatInc(row);
            end
            if (loadHi) begin
                hiByte <= data_p0;
                phase  <= 1'b1;
            end
            if (emitPix) begin
                phase <= 1'b0;
                col   <= colSatInc(col);
                if (inRange) begin
                    x_p1   <= col;
                    y_p1   <= row;
                    pix_p1 <= packRgb565(hiByte, data_p0);
                end
            end
        end
    end

    assign cam.outX       = x_p1;
    assign cam.outY       = y_p1;
    assign cam.outPixel   = pix_p1;
    assign cam.pixelValid = vld_p1;
    assign cam.frameDone  = done_p1;

endmodule

// File: tb/tb_camera_capture.sv
// Scoreboard bench for camera_capture on a reduced 16x6 active window.
module tb_camera_capture;

    localparam int H = 16;
    localparam int V = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    camera_capture_if bus();

    camera_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk(clk),
        .reset(reset),
        .cam(bus)
    );

    int nVec = 0;
    int nErr = 0;
    int nPix = 0;
    int fdCount = 0;
    int expFd = 0;
    int lastX = 0;
    int lastY = 0;
    int lastPix = 0;
    int base = 0;

    logic [34:0] expQ[$];

    // Reference camera-side model state
    logic       mActive = 1'b0;
    logic       mPrevHref = 1'b0;
    logic       mPhase = 1'b0;
    logic [7:0] mHi = 8'h00;
    int         mCol = 0;
    int         mRow = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelByte(input logic [7:0] b, input logic h);
        if (mActive) begin
            if (mPrevHref && !h) begin
                if (mCol != 0 && mRow < V) mRow++;
                mCol   = 0;
                mPhase = 1'b0;
            end else if (h) begin
                if (!mPhase) begin
                    mHi = b;
                end else begin
                    if (mCol < H && mRow < V)
                        expQ.push_back({10'(mCol), 9'(mRow), mHi, b});
                    if (mCol < H) mCol++;
                end
                mPhase = ~mPhase;
            end
        end
        mPrevHref = h;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic h);
        @(negedge clk);
        bus.camPclk = 1'b0;
        bus.camData = b;
        bus.camHref = h;
        modelByte(b, h);
        repeat (2) @(negedge clk);
        bus.camPclk = 1'b1;
        @(negedge clk);
    endtask

    task automatic endLine();
        sendByte(8'h00, 1'b0);
        sendByte(8'h00, 1'b0);
    endtask

    task automatic sendLine(input int nBytes);
        for (int i = 0; i < nBytes; i++) sendByte(8'($urandom_range(0, 255)), 1'b1);
        endLine();
    endtask

    task automatic vsyncPulse();
        repeat (2) @(negedge clk);
        bus.camVsync = 1'b1;
        if (mActive) expFd++;
        mActive = 1'b0;
        repeat (12) @(negedge clk);
        bus.camVsync = 1'b0;
        repeat (12) @(negedge clk);
        mActive = 1'b1;
        mCol = 0;
        mRow = 0;
        mPhase = 1'b0;
    endtask

    task automatic idle();
        repeat (8) @(negedge clk);
    endtask

    task automatic chkOutputsZero();
        chk("rst_outX", 64'(bus.outX), 64'd0);
        chk("rst_outY", 64'(bus.outY), 64'd0);
        chk("rst_outPixel", 64'(bus.outPixel), 64'd0);
        chk("rst_pixelValid", 64'(bus.pixelValid), 64'd0);
        chk("rst_frameDone", 64'(bus.frameDone), 64'd0);
    endtask

    always @(negedge clk) begin
        if (bus.pixelValid) begin
            nPix++;
            lastX   = int'(bus.outX);
            lastY   = int'(bus.outY);
            lastPix = int'(bus.outPixel);
            if (expQ.size() == 0) begin
                chk("unexpected_pixel", 64'({bus.outX, bus.outY, bus.outPixel}), 64'h7_FFFF_FFFF);
            end else begin
                chk("pixel", 64'({bus.outX, bus.outY, bus.outPixel}), 64'(expQ.pop_front()));
            end
        end
        if (bus.frameDone) fdCount++;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.camPclk  = 1'b0;
        bus.camVsync = 1'b0;
        bus.camHref  = 1'b0;
        bus.camData  = 8'h00;
        repeat (3) @(negedge clk);
        chkOutputsZero();
        reset = 1'b0;
        idle();

        // Powered with vsync low: href activity alone must not produce pixels
        sendLine(8);
        sendLine(8);
        idle();
        chk("no_pix_before_vsync", 64'(nPix), 64'd0);

        // First frame: one line F8 00 07 E0
        vsyncPulse();
        sendByte(8'hF8, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h07, 1'b1);
        sendByte(8'hE0, 1'b1);
        endLine();
        idle();
        chk("first_line_count", 64'(nPix), 64'd2);
        chk("first_line_lastX", 64'(lastX), 64'd1);
        chk("first_line_lastPix", 64'(lastPix), 64'h07E0);
        chk("first_line_no_done", 64'(fdCount), 64'd0);

        // Full frame followed by a vsync rise
        vsyncPulse();
        base = nPix;
        for (int r = 0; r < V; r++) sendLine(2 * H);
        idle();
        chk("frame_count", 64'(nPix - base), 64'(H * V));
        chk("frame_lastX", 64'(lastX), 64'(H - 1));
        chk("frame_lastY", 64'(lastY), 64'(V - 1));
        vsyncPulse();
        chk("frame_done_count", 64'(fdCount), 64'(expFd));
        chk("frame_done_total", 64'(fdCount), 64'd2);

        // Over-long line clipped at H, row advances once
        base = nPix;
        sendLine(2 * (H + 5));
        sendLine(2);
        idle();
        chk("long_line_count", 64'(nPix - base), 64'(H + 1));
        chk("long_line_nextX", 64'(lastX), 64'd0);
        chk("long_line_nextY", 64'(lastY), 64'd1);

        // Odd byte count: trailing byte dropped, next line re-pairs from x=0
        vsyncPulse();
        base = nPix;
        sendLine(5);
        sendLine(4);
        idle();
        chk("odd_line_count", 64'(nPix - base), 64'd4);
        chk("odd_next_lastX", 64'(lastX), 64'd1);
        chk("odd_next_lastY", 64'(lastY), 64'd1);

        // Lines beyond V are dropped
        vsyncPulse();
        base = nPix;
        for (int r = 0; r < V + 2; r++) sendLine(4);
        idle();
        chk("extra_rows_count", 64'(nPix - base), 64'(2 * V));
        chk("extra_rows_lastY", 64'(lastY), 64'(V - 1));

        // Vsync rise in the same sample as href fall
        sendByte(8'h12, 1'b1);
        sendByte(8'h34, 1'b1);
        @(negedge clk);
        bus.camPclk  = 1'b0;
        bus.camHref  = 1'b0;
        bus.camVsync = 1'b1;
        if (mActive) expFd++;
        mActive = 1'b0;
        mPrevHref = 1'b0;
        repeat (12) @(negedge clk);
        bus.camVsync = 1'b0;
        repeat (12) @(negedge clk);
        mActive = 1'b1;
        mCol = 0;
        mRow = 0;
        mPhase = 1'b0;
        chk("simul_edge_done", 64'(fdCount), 64'(expFd));

        // Reset mid-line at pixel 10, then ignore until the next full vsync
        base = nPix;
        for (int i = 0; i < 20; i++) sendByte(8'(i * 7 + 3), 1'b1);
        idle();
        chk("pre_reset_count", 64'(nPix - base), 64'd10);
        reset = 1'b1;
        mActive = 1'b0;
        mPrevHref = 1'b0;
        @(negedge clk);
        chkOutputsZero();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = nPix;
        for (int i = 0; i < 12; i++) sendByte(8'($urandom_range(0, 255)), 1'b1);
        endLine();
        sendLine(8);
        idle();
        chk("post_reset_ignored", 64'(nPix - base), 64'd0);
        vsyncPulse();
        sendByte(8'hAB, 1'b1);
        sendByte(8'hCD, 1'b1);
        sendByte(8'h01, 1'b1);
        sendByte(8'h23, 1'b1);
        endLine();
        idle();
        chk("post_reset_count", 64'(nPix - base), 64'd2);
        chk("post_reset_lastX", 64'(lastX), 64'd1);
        chk("post_reset_lastY", 64'(lastY), 64'd0);
        chk("post_reset_lastPix", 64'(lastPix), 64'h0123);
        chk("post_reset_done", 64'(fdCount), 64'(expFd));
        chk("scoreboard_empty", 64'(expQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
